// File: rtl/opb_register_bank.sv
// OPB slave window holding C_NUM_REGS software registers for user logic,
// with optional shadow copies that reach the outputs together on commit.
module opb_register_bank #(
    parameter logic [31:0] C_BASEADDR    = 32'h01000B00,
    parameter logic [31:0] C_HIGHADDR    = 32'h01000BFF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 8,
    parameter int          C_SHADOW      = 1,
    parameter logic [31:0] C_RESET_VALUE = 32'h00000000,
    parameter string       C_FAMILY      = "virtex5"
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]    OPB_ABus,
    input  logic [0:3]                 OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]    OPB_DBus,
    input  logic                       OPB_RNW,
    input  logic                       OPB_select,
    input  logic                       OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]    Sl_DBus,
    output logic                       Sl_xferAck,
    output logic                       Sl_errAck,
    output logic                       Sl_retry,
    output logic                       Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0]   user_data_out,
    output logic [C_NUM_REGS-1:0]      user_update,
    output logic                       user_commit
);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0] r_shadow [C_NUM_REGS];
    logic [31:0] r_active [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] r_dirty;
    logic [C_NUM_REGS-1:0] r_update;
    logic [15:0] r_count;
    logic        r_commit;

    logic [31:0] w_addr;
    logic [31:0] w_off;
    logic [31:0] w_wdata;
    logic [31:0] w_rdata;
    logic [3:0]  w_be;
    logic [29:0] w_word;
    logic        w_hit;
    logic        w_is_reg;
    logic        w_is_ctl;
    logic        w_wr;
    logic        w_commit;
    logic        w_unused;

    // Big-endian bus vectors map position-wise onto little-endian words.
    assign w_addr  = OPB_ABus;
    assign w_wdata = OPB_DBus;
    assign w_be    = OPB_BE;

    assign w_hit    = OPB_select && (w_addr >= C_BASEADDR)
                      && (w_addr <= C_HIGHADDR);
    assign w_off    = w_addr - C_BASEADDR;
    assign w_word   = w_off[31:2];
    assign w_is_reg = (w_word < 30'(C_NUM_REGS));
    assign w_is_ctl = (w_word == 30'(C_NUM_REGS));
    assign w_wr     = (r_state == S_ACK) && !OPB_RNW;
    assign w_commit = (C_SHADOW != 0) && w_wr && w_is_ctl
                      && w_be[0] && w_wdata[0];
    assign w_unused = ^{OPB_seqAddr, w_off[1:0]};

    function automatic logic [31:0] f_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) v[8*b +: 8] = new_v[8*b +: 8];
        end
        return v;
    endfunction

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_hit) w_next = S_ACK;
            S_ACK:   w_next = S_WAIT;
            S_WAIT:  if (!OPB_select) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (w_is_reg) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (w_word == 30'(i)) begin
                    w_rdata = (C_SHADOW != 0) ? r_shadow[i] : r_active[i];
                end
            end
        end else if (w_is_ctl && (C_SHADOW != 0)) begin
            w_rdata = {|r_dirty, 15'd0, r_count};
        end
    end

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_shadow[i] <= C_RESET_VALUE;
                r_active[i] <= C_RESET_VALUE;
            end
            r_dirty  <= '0;
            r_update <= '0;
            r_count  <= '0;
            r_commit <= 1'b0;
        end else begin
            r_update <= '0;
            r_commit <= 1'b0;
            if (w_wr && w_is_reg && (|w_be)) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (w_word == 30'(i)) begin
                        r_shadow[i] <= f_merge(r_shadow[i], w_wdata, w_be);
                        if (C_SHADOW != 0) begin
                            r_dirty[i] <= 1'b1;
                        end else begin
                            r_active[i] <= f_merge(r_active[i], w_wdata, w_be);
                            r_update[i] <= 1'b1;
                        end
                    end
                end
            end
            if (w_commit) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
                r_update <= r_dirty;
                r_commit <= 1'b1;
                r_dirty  <= '0;
                r_count  <= r_count + 16'd1;
            end
        end
    end

    // Outputs are masked during reset so an aborted transfer never acks.
    assign Sl_xferAck = (r_state == S_ACK) && !OPB_Rst;
    assign Sl_DBus    = ((r_state == S_ACK) && OPB_RNW && !OPB_Rst)
                        ? w_rdata : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = r_active[g];
    end

    assign user_update = r_update;
    assign user_commit = r_commit;

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench: one direct-mode and one shadow-mode bank on a shared bus.
module tb_opb_register_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [0:31] abus;
    logic [0:31] dbus;
    logic [0:3]  be;
    logic        rnw;
    logic        sel;
    logic        seq;

    logic [0:31]  sdb0, sdb1;
    logic         ack0, ack1;
    logic         err0, err1, rty0, rty1, to0, to1;
    logic [255:0] udo0, udo1;
    logic [7:0]   upd0, upd1;
    logic         cm0, cm1;

    opb_register_bank #(.C_SHADOW(0)) u_sh0 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel),
        .OPB_seqAddr(seq), .Sl_DBus(sdb0), .Sl_xferAck(ack0),
        .Sl_errAck(err0), .Sl_retry(rty0), .Sl_toutSup(to0),
        .user_data_out(udo0), .user_update(upd0), .user_commit(cm0)
    );

    opb_register_bank #(.C_SHADOW(1)) u_sh1 (
        .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be),
        .OPB_DBus(dbus), .OPB_RNW(rnw), .OPB_select(sel),
        .OPB_seqAddr(seq), .Sl_DBus(sdb1), .Sl_xferAck(ack1),
        .Sl_errAck(err1), .Sl_retry(rty1), .Sl_toutSup(to1),
        .user_data_out(udo1), .user_update(upd1), .user_commit(cm1)
    );

    int n_vec = 0;
    int n_bad = 0;
    int stray = 0;
    int nack0, nack1, upc0, upc1, cmc0, cmc1;
    logic [31:0] rd0, rd1;
    logic [7:0]  upa0, upa1;
    logic [255:0] e1;

    localparam logic [31:0] CTL = 32'h01000B20;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        sel = 1'b0; rnw = 1'b0; abus = '0; dbus = '0; be = '0; seq = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic sample();
        if (ack0) begin nack0++; rd0 = sdb0; end
        if (ack1) begin nack1++; rd1 = sdb1; end
        if ((!ack0 && sdb0 != 0) || (!ack1 && sdb1 != 0)) stray++;
        upa0 |= upd0;
        upa1 |= upd1;
        if (upd0 != 0) upc0++;
        if (upd1 != 0) upc1++;
        if (cm0) cmc0++;
        if (cm1) cmc1++;
    endtask

    task automatic clr();
        nack0 = 0; nack1 = 0; rd0 = '0; rd1 = '0; upa0 = '0; upa1 = '0;
        upc0 = 0; upc1 = 0; cmc0 = 0; cmc1 = 0;
    endtask

    // Select is held for 'hold' edges, then the bus watches a few more.
    task automatic xfer(input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        input int hold);
        clr();
        rnw = r; abus = a; dbus = d; be = b; sel = 1'b1;
        for (int k = 1; k <= hold + 3; k++) begin
            @(posedge clk); #1;
            sample();
            if (k == hold) sel = 1'b0;
        end
        idle_bus();
    endtask

    task automatic rd(input logic [31:0] a);
        xfer(1'b1, a, 32'h0, 4'b1111, 2);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b);
        xfer(1'b0, a, d, b, 2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_ack", {ack0, ack1, sdb0, sdb1}, 0);
        check("rst_udo0", udo0, 0);
        check("rst_udo1", udo1, 0);
        check("rst_pulse", {upd0, upd1, cm0, cm1}, 0);
        check("const0", {err0, rty0, to0, err1, rty1, to1}, 0);

        rd(32'h01000B0C);
        check("rd3_ack", {nack0, nack1}, {32'd1, 32'd1});
        check("rd3_data", {rd0, rd1}, 0);

        wr(32'h01000B08, 32'hDEADBEEF, 4'b1111);
        check("w2_udo0", udo0[95:64], 32'hDEADBEEF);
        check("w2_upd0", upa0, 8'b00000100);
        check("w2_updc0", upc0, 1);
        check("w2_udo1", udo1, 0);
        check("w2_upd1", upa1, 0);
        rd(32'h01000B08);
        check("rb2", {rd0, rd1}, {32'hDEADBEEF, 32'hDEADBEEF});
        rd(CTL);
        check("ctl_pend", {rd0, rd1}, {32'h0, 32'h80000000});

        wr(32'h01000B00, 32'h11223344, 4'b1111);
        wr(32'h01000B00, 32'hAABBCCDD, 4'b0101);
        check("be_udo0", udo0[31:0], 32'h11BB33DD);
        rd(32'h01000B00);
        check("be_rb", {rd0, rd1}, {32'h11BB33DD, 32'h11BB33DD});
        wr(32'h01000B00, 32'hFFFFFFFF, 4'b0000);
        check("be0_ack", {nack0, nack1}, {32'd1, 32'd1});
        check("be0_upd", upc0, 0);
        rd(32'h01000B00);
        check("be0_rb", {rd0, rd1}, {32'h11BB33DD, 32'h11BB33DD});

        do_reset();
        wr(32'h01000B10, 32'h00000005, 4'b1111);
        wr(32'h01000B14, 32'h00000007, 4'b1111);
        check("sh_hold", udo1, 0);
        check("sh_direct", udo0[191:128], {32'h7, 32'h5});
        rd(CTL);
        check("sh_ctl", rd1, 32'h80000000);
        wr(CTL, 32'h00000001, 4'b1111);
        e1 = '0;
        e1[191:128] = {32'h7, 32'h5};
        check("cm_udo1", udo1, e1);
        check("cm_upd1", upa1, 8'b00110000);
        check("cm_pulse", {upc1, cmc1}, {32'd1, 32'd1});
        check("cm_sh0", {upc0, cmc0}, 0);
        rd(CTL);
        check("cm_ctl", rd1, 32'h00000001);
        wr(CTL, 32'h00000001, 4'b1111);
        check("cm_clean", {upc1, cmc1}, {32'd0, 32'd1});
        rd(CTL);
        check("cm_ctl2", rd1, 32'h00000002);
        wr(CTL, 32'h00000001, 4'b1110);
        check("cm_nobe3", cmc1, 0);
        wr(CTL, 32'h80000000, 4'b1111);
        check("cm_bit0", cmc1, 0);
        rd(CTL);
        check("cm_ctl3", rd1, 32'h00000002);

        wr(32'h01000B40, 32'hFFFFFFFF, 4'b1111);
        check("nul_wack", {nack0, nack1}, {32'd1, 32'd1});
        check("nul_upd", {upc0, upc1, cmc1}, 0);
        check("nul_udo1", udo1, e1);
        rd(32'h01000B40);
        check("nul_rd", {nack0, nack1, rd0, rd1}, {32'd1, 32'd1, 64'd0});
        rd(32'h01000BFC);
        check("top_rd", {nack1, rd1}, {32'd1, 32'd0});
        rd(32'h01000C00);
        check("out_hi", {nack0, nack1}, 0);
        rd(32'h01000AFC);
        check("out_lo", {nack0, nack1}, 0);
        xfer(1'b1, 32'h01000B10, 32'h0, 4'b1111, 5);
        check("hold5", {nack0, nack1}, {32'd1, 32'd1});
        check("hold5_rd", {rd0, rd1}, {32'h5, 32'h5});

        wr(32'h01000B04, 32'h12345678, 4'b1111);
        wr(CTL, 32'h00000001, 4'b1111);
        check("pre_rst", {udo0[63:32], udo1[63:32]},
              {32'h12345678, 32'h12345678});
        clr();
        rst = 1'b1; sel = 1'b1; rnw = 1'b0; be = 4'b1111;
        abus = 32'h01000B04; dbus = 32'hCAFEF00D;
        @(posedge clk); #1;
        sample();
        rst = 1'b0;
        idle_bus();
        repeat (4) begin
            @(posedge clk); #1;
            sample();
        end
        check("mr_noack", {nack0, nack1}, 0);
        check("mr_udo0", udo0, 0);
        check("mr_udo1", udo1, 0);
        rd(32'h01000B04);
        check("mr_rb", {rd0, rd1}, 0);
        rd(CTL);
        check("mr_ctl", rd1, 0);
        wr(32'h01000B04, 32'h0000ABCD, 4'b1111);
        rd(32'h01000B04);
        check("mr_after", {nack0, nack1, rd0, rd1},
              {32'd1, 32'd1, 32'h0000ABCD, 32'h0000ABCD});
        check("stray_dbus", stray, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
